// File: rtl/power_spec_accum.sv
// Power spectrum |X|^2 per FFT bin, summed over avg_num frames in a per-bin RAM.
// Optional saturation and sticky overflow flag: define POWER_SPEC_SAT_EN.
module power_spec_accum #(
    parameter int unsigned DW        = 16,
    parameter int unsigned NFFT_LOG2 = 10,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned AVG_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [DW-1:0]    xk_re,
    input  logic signed [DW-1:0]    xk_im,
    input  logic [NFFT_LOG2-1:0]    xk_index,
    input  logic                    dv,
    input  logic [AVG_W-1:0]        avg_num,
    output logic [ACC_W-1:0]        out_data,
    output logic [NFFT_LOG2-1:0]    out_index,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [AVG_W-1:0]        frame_cnt,
    output logic                    overflow
);

    localparam int unsigned DEPTH = 2 ** NFFT_LOG2;
    localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

    logic                        s1_v, s2_v, s3_v;
    logic signed [DW-1:0]        s1_re, s1_im;
    logic [NFFT_LOG2-1:0]        s1_idx, s2_idx, s3_idx;
    logic [AVG_W-1:0]            s1_avg, s2_avg, s3_avg;
    logic signed [2*DW-1:0]      s2_re_sq, s2_im_sq;
    logic [2*DW-1:0]             s3_p;

    logic [ACC_W-1:0]            ram [DEPTH];
    logic [ACC_W-1:0]            ram_rd;

    logic                        cycle_active;
    logic [AVG_W-1:0]            avg_lat, avg_eff;
    logic                        first, last_frame, frame_end;
    logic [ACC_W-1:0]            acc_base, acc;
`ifdef POWER_SPEC_SAT_EN
    logic [ACC_W:0]              sum;
    logic                        ovf_hit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= dv;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
        if (dv) begin
            s1_re  <= xk_re;
            s1_im  <= xk_im;
            s1_idx <= xk_index;
            s1_avg <= avg_num;
        end
        if (s1_v) begin
            s2_re_sq <= (2*DW)'(s1_re) * (2*DW)'(s1_re);
            s2_im_sq <= (2*DW)'(s1_im) * (2*DW)'(s1_im);
            s2_idx   <= s1_idx;
            s2_avg   <= s1_avg;
        end
        if (s2_v) begin
            s3_p   <= $unsigned(s2_re_sq) + $unsigned(s2_im_sq);
            s3_idx <= s2_idx;
            s3_avg <= s2_avg;
        end
    end

    // Read is issued alongside S3 so the stored sum lines up with s3_p at S4.
    always_ff @(posedge clk) begin
        ram_rd <= ram[s2_idx];
        if (s3_v)
            ram[s3_idx] <= acc;
    end

    // avg_num travels with the sample, so latching it at S4 on the first sample
    // of a cycle is equivalent to latching it at that sample's dv.
    always_comb begin
        avg_eff    = cycle_active ? avg_lat : ((s3_avg == '0) ? AVG_W'(1) : s3_avg);
        first      = (frame_cnt == '0);
        last_frame = (frame_cnt == avg_eff - AVG_W'(1));
        frame_end  = s3_v && (s3_idx == LAST_BIN);
        acc_base   = first ? '0 : ram_rd;
`ifdef POWER_SPEC_SAT_EN
        sum        = {1'b0, acc_base} + (ACC_W+1)'(s3_p);
        ovf_hit    = s3_v && sum[ACC_W];
        acc        = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc        = acc_base + ACC_W'(s3_p);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data     <= '0;
            out_index    <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            frame_cnt    <= '0;
            cycle_active <= 1'b0;
            avg_lat      <= '0;
        end else begin
            out_valid <= s3_v && last_frame;
            out_last  <= s3_v && last_frame && (s3_idx == LAST_BIN);
            if (s3_v && last_frame) begin
                out_data  <= acc;
                out_index <= s3_idx;
            end
            if (s3_v) begin
                if (!cycle_active)
                    avg_lat <= avg_eff;
                cycle_active <= !(frame_end && last_frame);
            end
            if (frame_end)
                frame_cnt <= last_frame ? '0 : frame_cnt + AVG_W'(1);
        end
    end

`ifdef POWER_SPEC_SAT_EN
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (s3_v && !cycle_active)
            overflow <= ovf_hit;
        else if (ovf_hit)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_power_spec_accum.sv
// Directed bench for power_spec_accum: a 40-bit instance plus a 33-bit instance
// for the accumulator-limit case; expectations follow POWER_SPEC_SAT_EN.
module tb_power_spec_accum;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] xk_re = '0;
    logic signed [15:0] xk_im = '0;
    logic [9:0]         xk_index = '0;
    logic               dv = 1'b0;
    logic [7:0]         avg_num = 8'd1;

    logic [39:0] out_data;
    logic [9:0]  out_index;
    logic        out_valid, out_last, overflow;
    logic [7:0]  frame_cnt;

    logic [32:0] out_data33;
    logic [9:0]  out_index33;
    logic        out_valid33, out_last33, overflow33;
    logic [7:0]  frame_cnt33;

    power_spec_accum #(.DW(16), .NFFT_LOG2(10), .ACC_W(40), .AVG_W(8)) u_dut (
        .clk(clk), .rst(rst), .xk_re(xk_re), .xk_im(xk_im), .xk_index(xk_index),
        .dv(dv), .avg_num(avg_num), .out_data(out_data), .out_index(out_index),
        .out_valid(out_valid), .out_last(out_last), .frame_cnt(frame_cnt),
        .overflow(overflow)
    );

    power_spec_accum #(.DW(16), .NFFT_LOG2(10), .ACC_W(33), .AVG_W(8)) u_dut33 (
        .clk(clk), .rst(rst), .xk_re(xk_re), .xk_im(xk_im), .xk_index(xk_index),
        .dv(dv), .avg_num(avg_num), .out_data(out_data33), .out_index(out_index33),
        .out_valid(out_valid33), .out_last(out_last33), .frame_cnt(frame_cnt33),
        .overflow(overflow33)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int in_cyc [1024];
    longint unsigned got_data [1024];
    int got_lat [1024];
    longint unsigned got33 [1024];
    int vcount, v33count, lcount, last_idx;
    int fcq [$];
    logic [7:0] prev_fc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            vcount++;
            got_data[out_index] = longint'(out_data);
            got_lat[out_index]  = cyc - in_cyc[out_index];
        end
        if (out_last === 1'b1) begin
            lcount++;
            last_idx = int'(out_index);
        end
        if (out_valid33 === 1'b1) begin
            v33count++;
            got33[out_index33] = longint'(out_data33);
        end
        if (frame_cnt !== prev_fc) begin
            fcq.push_back(int'(frame_cnt));
            prev_fc = frame_cnt;
        end
    end

    task automatic clear_capture();
        for (int i = 0; i < 1024; i++) begin
            got_data[i] = '1;
            got33[i]    = '1;
            got_lat[i]  = -1;
        end
        vcount = 0; v33count = 0; lcount = 0; last_idx = -1;
        fcq.delete();
        prev_fc = frame_cnt;
    endtask

    task automatic drive(input int idx, input int re, input int im);
        xk_re    = 16'(re);
        xk_im    = 16'(im);
        xk_index = 10'(idx);
        dv       = 1'b1;
        in_cyc[idx] = cyc;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        dv = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        dv  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int re, input int im, input int sp_bin,
                              input int sp_re, input int sp_im,
                              input int nbins, input bit gap);
        for (int i = 0; i < nbins; i++) begin
            if (gap && i > 0 && (i % 100) == 0)
                idle(3);
            if (i == sp_bin) drive(i, sp_re, sp_im);
            else             drive(i, re, im);
        end
    endtask

    task automatic test_reset();
        pulse_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 40'd0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_cmp++; if (out_index !== 10'd0) begin n_bad++; $display("FAIL reset_out_index got %0d want 0", out_index); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (out_valid33 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid33 got %b want 0", out_valid33); end
    endtask

    task automatic test_single_bin();
        int bad = 0;
        avg_num = 8'd1;
        clear_capture();
        send_frame(0, 0, 5, 3, 4, 1024, 1'b0);
        idle(8);
        for (int i = 0; i < 1024; i++)
            if (i != 5 && got_data[i] != 0) bad++;
        n_cmp++; if (vcount !== 1024) begin n_bad++; $display("FAIL single_valid_count got %0d want 1024", vcount); end
        n_cmp++; if (got_data[5] !== 64'd25) begin n_bad++; $display("FAIL single_bin5_data got %0d want 25", got_data[5]); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL single_zero_bins got %0d bad want 0", bad); end
        n_cmp++; if (got_lat[5] !== 4) begin n_bad++; $display("FAIL single_bin5_latency got %0d want 4", got_lat[5]); end
        n_cmp++; if (lcount !== 1) begin n_bad++; $display("FAIL single_last_count got %0d want 1", lcount); end
        n_cmp++; if (last_idx !== 1023) begin n_bad++; $display("FAIL single_last_index got %0d want 1023", last_idx); end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL single_frame_cnt got %0d want 0", frame_cnt); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        bit seq_ok;
        avg_num = 8'd4;
        clear_capture();
        repeat (4) send_frame(1000, 0, -1, 0, 0, 1024, 1'b0);
        idle(8);
        for (int i = 0; i < 1024; i++)
            if (got_data[i] != 64'd4000000) bad++;
        seq_ok = (fcq.size() == 4) && (fcq[0] == 1) && (fcq[1] == 2) && (fcq[2] == 3) && (fcq[3] == 0);
        n_cmp++; if (vcount !== 1024) begin n_bad++; $display("FAIL b2b_valid_count got %0d want 1024", vcount); end
        n_cmp++; if (got_data[0] !== 64'd4000000) begin n_bad++; $display("FAIL b2b_bin0_data got %0d want 4000000", got_data[0]); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL b2b_all_bins got %0d bad want 0", bad); end
        n_cmp++; if (seq_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_frame_cnt_seq got %0d steps want 1,2,3,0", fcq.size()); end
        n_cmp++; if (lcount !== 1) begin n_bad++; $display("FAIL b2b_last_count got %0d want 1", lcount); end
    endtask

    task automatic test_full_scale();
        int bad = 0;
        avg_num = 8'd1;
        clear_capture();
        send_frame(-32768, -32768, -1, 0, 0, 1024, 1'b0);
        idle(8);
        for (int i = 0; i < 1024; i++)
            if (got_data[i] != 64'h8000_0000) bad++;
        n_cmp++; if (vcount !== 1024) begin n_bad++; $display("FAIL fullscale_valid_count got %0d want 1024", vcount); end
        n_cmp++; if (got_data[0] !== 64'h8000_0000) begin n_bad++; $display("FAIL fullscale_bin0 got %0h want 80000000", got_data[0]); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL fullscale_all_bins got %0d bad want 0", bad); end
    endtask

    task automatic test_saturation();
        int bad = 0;
        longint unsigned exp33;
        logic exp_ovf;
`ifdef POWER_SPEC_SAT_EN
        exp33 = 64'h1_FFFF_FFFF;
        exp_ovf = 1'b1;
`else
        exp33 = 64'd0;
        exp_ovf = 1'b0;
`endif
        pulse_reset();
        avg_num = 8'd4;
        clear_capture();
        repeat (4) send_frame(-32768, -32768, -1, 0, 0, 1024, 1'b0);
        idle(8);
        for (int i = 0; i < 1024; i++)
            if (got33[i] != exp33) bad++;
        n_cmp++; if (v33count !== 1024) begin n_bad++; $display("FAIL sat_valid_count got %0d want 1024", v33count); end
        n_cmp++; if (got33[1023] !== exp33) begin n_bad++; $display("FAIL sat_bin1023 got %0h want %0h", got33[1023], exp33); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL sat_all_bins got %0d bad want 0", bad); end
        n_cmp++; if (overflow33 !== exp_ovf) begin n_bad++; $display("FAIL sat_overflow33 got %b want %b", overflow33, exp_ovf); end
        n_cmp++; if (got_data[7] !== 64'h2_0000_0000) begin n_bad++; $display("FAIL sat_wide_bin7 got %0h want 200000000", got_data[7]); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat_wide_overflow got %b want 0", overflow); end
    endtask

    task automatic test_gaps();
        int bad = 0;
        int lat_bad = 0;
        avg_num = 8'd2;
        clear_capture();
        repeat (2) send_frame(7, -5, -1, 0, 0, 1024, 1'b1);
        idle(8);
        for (int i = 0; i < 1024; i++) begin
            if (got_data[i] != 64'd148) bad++;
            if (got_lat[i] != 4) lat_bad++;
        end
        n_cmp++; if (vcount !== 1024) begin n_bad++; $display("FAIL gaps_valid_count got %0d want 1024", vcount); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL gaps_all_bins got %0d bad want 0", bad); end
        n_cmp++; if (got_lat[999] !== 4) begin n_bad++; $display("FAIL gaps_bin999_latency got %0d want 4", got_lat[999]); end
        n_cmp++; if (lat_bad !== 0) begin n_bad++; $display("FAIL gaps_latency got %0d bad want 0", lat_bad); end
        n_cmp++; if (lcount !== 1) begin n_bad++; $display("FAIL gaps_last_count got %0d want 1", lcount); end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        avg_num = 8'd2;
        send_frame(500, 0, -1, 0, 0, 1024, 1'b0);
        send_frame(500, 0, -1, 0, 0, 501, 1'b0);
        pulse_reset();
        n_cmp++; if (frame_cnt !== 8'd0) begin n_bad++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
        clear_capture();
        repeat (2) send_frame(10, 0, -1, 0, 0, 1024, 1'b0);
        idle(8);
        for (int i = 0; i < 1024; i++)
            if (got_data[i] != 64'd200) bad++;
        n_cmp++; if (vcount !== 1024) begin n_bad++; $display("FAIL midrst_valid_count got %0d want 1024", vcount); end
        n_cmp++; if (got_data[0] !== 64'd200) begin n_bad++; $display("FAIL midrst_bin0 got %0d want 200", got_data[0]); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL midrst_all_bins got %0d bad want 0", bad); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single_bin();
        test_back_to_back();
        test_full_scale();
        test_saturation();
        test_gaps();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
